// File: rtl/minterm_scanner_pkg.sv
// Shared types and sizing helpers for the minterm scanner and its counter.
package minterm_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Truth-table width for a given number of function inputs.
  function automatic int tw_of(input int n_vars);
    return 32'sd1 << n_vars;
  endfunction

  // Settle counter width; a zero settle still needs a one-bit counter.
  function automatic int cnt_w_of(input int settle_cycles);
    if (settle_cycles < 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(settle_cycles + 32'sd1);
    end
  endfunction

endpackage

// File: rtl/minterm_scanner_counter.sv
// Minterm index and settle counter: holds each minterm for SETTLE_CYCLES+1 cycles,
// flags the sampling edge and the final minterm.
module minterm_counter
  import minterm_pkg::*;
#(
  parameter int N_VARS        = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_enable,
  output logic [N_VARS-1:0] o_idx,
  output logic              o_sample_en,
  output logic              o_last
);

  localparam int CW = cnt_w_of(SETTLE_CYCLES);
  localparam logic [CW-1:0]     SETTLE_C = CW'(SETTLE_CYCLES);
  localparam logic [N_VARS-1:0] LAST_IDX = {N_VARS{1'b1}};

  logic [N_VARS-1:0] r_idx;
  logic [CW-1:0]     r_cnt;
  logic              w_sample_en;
  logic              w_last;

  assign w_sample_en = i_enable && (r_cnt == SETTLE_C);
  assign w_last      = (r_idx == LAST_IDX);

  // Settle-and-advance; the index stops on the last minterm instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
      r_cnt <= '0;
    end else if (w_sample_en) begin
      r_cnt <= '0;
      if (!w_last) begin
        r_idx <= r_idx + N_VARS'(1);
      end else begin
        r_idx <= r_idx;
      end
    end else if (i_enable) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_idx       = r_idx;
  assign o_sample_en = w_sample_en;
  assign o_last      = w_last;

endmodule

// File: rtl/minterm_scanner.sv
// Walks an external Boolean function through all minterms, captures its truth
// table and compares it against an expected mask latched at start.
module minterm_scanner
  import minterm_pkg::*;
#(
  parameter  int N_VARS        = 3,
  parameter  int SETTLE_CYCLES = 1,
  localparam int TW            = tw_of(N_VARS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [TW-1:0]     expected,
  input  logic              f_in,
  output logic [N_VARS-1:0] vars_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [TW-1:0]     truth_table,
  output logic [TW-1:0]     mismatch
);

  state_t            r_state;
  logic [N_VARS-1:0] r_vars;
  logic [TW-1:0]     r_exp;
  logic [TW-1:0]     r_table;
  logic [TW-1:0]     r_mismatch;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;

  logic              w_accept;
  logic              w_scan;
  logic [N_VARS-1:0] w_idx;
  logic              w_sample_en;
  logic              w_last;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_scan   = (r_state == S_SCAN);

  minterm_counter #(
    .N_VARS       (N_VARS),
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (w_accept),
    .i_enable   (w_scan),
    .o_idx      (w_idx),
    .o_sample_en(w_sample_en),
    .o_last     (w_last)
  );

  // Scan FSM; the compare runs in DONE off the completed table so pass and
  // mismatch become valid together with the done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_vars     <= '0;
      r_exp      <= '0;
      r_table    <= '0;
      r_mismatch <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_vars <= '0;
          if (start) begin
            r_exp   <= expected;
            r_table <= '0;
            r_busy  <= 1'b1;
            r_state <= S_SCAN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_SCAN: begin
          if (w_sample_en) begin
            r_table[w_idx] <= f_in;
            if (w_last) begin
              r_vars  <= '0;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_vars <= r_vars + N_VARS'(1);
            end
          end else begin
            r_vars <= r_vars;
          end
        end
        S_DONE: begin
          r_done     <= 1'b1;
          r_pass     <= (r_table == r_exp);
          r_mismatch <= r_table ^ r_exp;
          r_state    <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_vars  <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign vars_out    = r_vars;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign truth_table = r_table;
  assign mismatch    = r_mismatch;

endmodule

// File: tb/tb_minterm_scanner.sv
// Scoreboard bench: two scanners (settle 1 with F=A^B^C, settle 0 with F=A&B).
module tb_minterm_scanner;

  typedef struct {
    int         done_cyc;
    logic [7:0] tbl;
    logic [7:0] mis;
    logic       pass;
  } item_t;

  logic       clk;
  logic       rst_n;
  logic       start0, start1;
  logic [7:0] exp0, exp1;
  logic       f0, f1;
  logic [2:0] vars0, vars1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [7:0] tbl0, tbl1, mis0, mis1;

  int    checks;
  int    errors;
  int    cyc;
  int    c0;
  item_t q0[$];
  item_t q1[$];
  logic [7:0] xor_tbl, and_tbl;

  minterm_scanner #(.N_VARS(3), .SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .expected(exp0), .f_in(f0),
    .vars_out(vars0), .busy(busy0), .done(done0), .pass(pass0),
    .truth_table(tbl0), .mismatch(mis0)
  );

  minterm_scanner #(.N_VARS(3), .SETTLE_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1), .f_in(f1),
    .vars_out(vars1), .busy(busy1), .done(done1), .pass(pass1),
    .truth_table(tbl1), .mismatch(mis1)
  );

  assign f0 = vars0[2] ^ vars0[1] ^ vars0[0];
  assign f1 = vars1[2] & vars1[1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic item_t mk(input int dc, input logic [7:0] tbl, input logic [7:0] e);
    item_t it;
    it.done_cyc = dc;
    it.tbl      = tbl;
    it.mis      = tbl ^ e;
    it.pass     = (tbl == e);
    return it;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding scan.
  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) begin
        check_val("dut0_spurious_done", 32'd1, 32'd0);
      end else begin
        item_t it;
        it = q0.pop_front();
        check_val("dut0_latency", cyc, it.done_cyc);
        check_val("dut0_table", tbl0, it.tbl);
        check_val("dut0_pass", pass0, it.pass);
        check_val("dut0_mismatch", mis0, it.mis);
        check_val("dut0_busy_at_done", busy0, 32'd0);
      end
    end
    if (done1) begin
      if (q1.size() == 0) begin
        check_val("dut1_spurious_done", 32'd1, 32'd0);
      end else begin
        item_t it;
        it = q1.pop_front();
        check_val("dut1_latency", cyc, it.done_cyc);
        check_val("dut1_table", tbl1, it.tbl);
        check_val("dut1_pass", pass1, it.pass);
        check_val("dut1_mismatch", mis1, it.mis);
      end
    end
  end

  // Bounded wait until both scoreboards are empty, then settle into IDLE.
  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      check_val("drain_timeout", q0.size() + q1.size(), 32'd0);
      q0.delete();
      q1.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Pulse start on dut0 for one edge; c0 is the cycle count after the accepting edge.
  task automatic start_dut0(input logic [7:0] e);
    @(posedge clk); #1;
    start0 = 1'b1;
    exp0   = e;
    @(posedge clk); #1;
    start0 = 1'b0;
    c0     = cyc;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; exp0 = 8'h00; exp1 = 8'h00;
    for (int m = 0; m < 8; m++) begin
      logic [2:0] mv;
      mv = 3'(m);
      xor_tbl[m] = mv[2] ^ mv[1] ^ mv[0];
      and_tbl[m] = mv[2] & mv[1];
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_vars", vars0, 32'd0);
    check_val("rst_busy", busy0, 32'd0);
    check_val("rst_done", done0, 32'd0);
    check_val("rst_pass", pass0, 32'd0);
    check_val("rst_table", tbl0, 32'd0);
    check_val("rst_mismatch", mis0, 32'd0);

    // Matching scan, with minterm stepping checked cycle by cycle.
    start_dut0(8'h96);
    q0.push_back(mk(c0 + 17, xor_tbl, 8'h96));
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check_val($sformatf("vars_step%0d", k), vars0, k / 2);
      check_val($sformatf("busy_step%0d", k), busy0, 32'd1);
    end
    drain(40);

    // One wrong bit in the expected mask.
    start_dut0(8'h97);
    q0.push_back(mk(c0 + 17, xor_tbl, 8'h97));
    drain(40);

    // Restart attempt mid-scan with a different mask must be ignored.
    start_dut0(8'h96);
    q0.push_back(mk(c0 + 17, xor_tbl, 8'h96));
    repeat (4) @(posedge clk);
    #1 start0 = 1'b1; exp0 = 8'h00;
    @(posedge clk); #1 start0 = 1'b0;
    drain(40);

    // Reset for one edge at cycle 9 aborts the scan.
    start_dut0(8'h96);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("abort_vars", vars0, 32'd0);
    check_val("abort_busy", busy0, 32'd0);
    check_val("abort_table", tbl0, 32'd0);
    check_val("abort_pass", pass0, 32'd0);
    repeat (20) @(negedge clk);
    start_dut0(8'h96);
    q0.push_back(mk(c0 + 17, xor_tbl, 8'h96));
    drain(40);

    // Zero-settle instance: one minterm per cycle.
    @(posedge clk); #1;
    start1 = 1'b1; exp1 = 8'hC0;
    @(posedge clk); #1;
    start1 = 1'b0; c0 = cyc;
    q1.push_back(mk(c0 + 9, and_tbl, 8'hC0));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_val($sformatf("s0_vars%0d", k), vars1, k);
    end
    drain(30);

    // Start held high: back-to-back scans with a single idle cycle between.
    @(posedge clk); #1;
    start0 = 1'b1; exp0 = 8'h96;
    @(posedge clk); #1;
    c0 = cyc;
    q0.push_back(mk(c0 + 17, xor_tbl, 8'h96));
    q0.push_back(mk(c0 + 35, xor_tbl, 8'h96));
    repeat (18) @(negedge clk);
    check_val("b2b_done", done0, 32'd1);
    check_val("b2b_busy_gap", busy0, 32'd0);
    @(negedge clk);
    check_val("b2b_busy_again", busy0, 32'd1);
    check_val("b2b_pass_hold", pass0, 32'd1);
    @(posedge clk); #1 start0 = 1'b0;
    drain(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
